varray_rle: RTL and testbench
=============================

Name: varray_rle

Overview:
- Parametrised successor to the fixed 16-bit/64-entry virtual array: a sparse, monotonically addressed virtual array stored as a run-length queue.
- Each write pushes one run: an address range plus one data value.
- Reads walk the array in order. Addresses outside any run return FILL_VALUE, and runs are retired once the read passes their end.
- Adds over the previous generation: write backpressure, occupancy and full/empty flags, a read-valid strobe, and error detection. It sits between the cherry-core load/store FIFO producer and a streaming consumer.

Parameters:
- DATA_W, 18, width of an element.
- ADDR_BITS, 16, virtual address width.
- LOG_DEPTH, 6, log2 of the run-queue depth. DEPTH = 2**LOG_DEPTH.
- LEN_BITS, 5, width of the run length.
- FILL_VALUE, 0, value returned for unwritten addresses.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- we  in  1  write request.
- wr_ready  out  1  run queue can accept a write (= !full).
- write_addr  in  ADDR_BITS  first address of the run.
- write_len  in  LEN_BITS  run covers arr[write_addr +: write_len].
- dat_w  in  DATA_W  value of every element in the run.
- wr_err  out  1  one-cycle pulse: write rejected.
- re  in  1  read request.
- read_addr  in  ADDR_BITS  address to read.
- rd_valid  out  1  dat_r valid this cycle.
- dat_r  out  DATA_W  read data.
- rd_err  out  1  one-cycle pulse: read address out of order.
- varray_len  out  ADDR_BITS+1  one past the last written address.
- count  out  LOG_DEPTH+1  runs currently queued.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset (asynchronous, active-high; may be asserted mid-operation):
  - Clears head, tail, count, varray_len, rd_valid, wr_err, rd_err and dat_r (dat_r = FILL_VALUE).
  - After reset: empty=1, full=0, wr_ready=1.
  - Queue storage is not reset. Every read qualifies storage with count, so stale contents are never used.
- Write acceptance:
  - A write is accepted when we && wr_ready && write_len != 0 && write_addr >= varray_len.
  - On accept, the run {start=write_addr, end=write_addr+write_len, data=dat_w} is stored at head.
  - end is computed in ADDR_BITS+1 bits, so it never wraps.
  - head increments modulo DEPTH, and varray_len <= end.
- Write rejection:
  - we && full: dropped silently. The producer must honour wr_ready.
  - we && write_len == 0: dropped silently.
  - we && write_addr < varray_len (overlap or non-monotonic): dropped, and wr_err pulses the next cycle.
- Read (1-cycle latency). When re is high in cycle N, then in cycle N+1 rd_valid=1 and dat_r is:
  - FILL_VALUE if the queue was empty at N;
  - FILL_VALUE if read_addr < start[tail];
  - data[tail] if start[tail] <= read_addr < end[tail];
  - FILL_VALUE if read_addr >= end[tail]. In this case rd_err also pulses in N+1.
- rd_valid is 0 in any cycle that does not follow an re.
- Retire (pop):
  - If the queue is non-empty and read_addr+1 >= end[tail] (ADDR_BITS+1 compare), tail increments modulo DEPTH at the end of cycle N.
  - At most one run retires per read.
- Read monotonicity:
  - read_addr must be strictly increasing across reads.
  - A read address <= the previous read address also pulses rd_err. Its data is still returned per the rules above.
- Simultaneous write and read:
  - The read sees the pre-write queue. A write into an empty queue in the same cycle as a read yields FILL_VALUE.
  - count <= count + push - pop, so push and pop in the same cycle leave count unchanged.
  - full is evaluated before the pop: a write when full is rejected even if a pop occurs the same cycle.
- Pointers wrap at DEPTH. count distinguishes full from empty when head == tail.
- full, empty, count and wr_ready are registered and reflect state after the last edge.

Decomposition:
- varray_pkg holds:
  - the run record typedef (start ADDR_BITS, end ADDR_BITS+1, data DATA_W);
  - default parameter constants;
  - the FILL_VALUE default.
- Sub-module varray_run_fifo: DEPTH-entry circular storage with head/tail/count, push/pop and full/empty, with asynchronous reset.
- varray_rle adds the address comparisons, error logic and the read output register.

Test Plan:
- Basic run and gap:
  - Stimulus: reset; write (addr 4, len 3, dat 0x155); read addresses 0..7.
  - Required: dat_r = 0,0,0,0,0x155,0x155,0x155,0, each with rd_valid one cycle after re.
  - Required: count returns to 0 after the read of addr 6; varray_len = 7.
- Full and backpressure:
  - Stimulus: 64 writes of len 1 at addr 0..63; then a write at addr 64.
  - Required: after the 64th write, full=1 and wr_ready=0. The write at addr 64 is dropped, count stays 64 and varray_len stays 64.
  - Stimulus continued: read addr 0, then write at addr 64.
  - Required: the write is accepted.
- Write errors:
  - Stimulus: write (addr 10, len 2); then write (addr 11, len 1); then write (addr 12, len 0).
  - Required: the second write gives a wr_err pulse and is dropped. The third is ignored with no wr_err. varray_len = 12 and count = 1.
- Read errors:
  - Stimulus: write (addr 0, len 4, dat 7) and (addr 8, len 2, dat 9); read addresses 1, 1, 6, 8.
  - Required: second read → rd_err=1, dat_r=7.
  - Required: read 6 → rd_err=1, dat_r=0, and the first run retires.
  - Required: read 8 → dat_r=9.
- Simultaneous events:
  - Stimulus: on an empty queue, we (addr 0, len 1, dat 3) and re (addr 0) in the same cycle.
  - Required: dat_r=0 and count=1.
  - Stimulus continued: on the next cycle, read addr 0 together with write (addr 1, len 1).
  - Required: dat_r=3 and count stays 1.
- Reset mid-operation and wrap-around:
  - Stimulus: with count=5, assert reset asynchronously mid-cycle.
  - Required: empty=1, rd_valid=0 and varray_len=0 immediately.
  - Stimulus continued: 200 push/read cycles.
  - Required: head and tail wrap and all data matches the model.

Source files
------------

// File: rtl/varray_pkg.sv
// rtl/varray_pkg.sv - shared constants and run record for the run-length virtual array
package varray_pkg;

    localparam int DEF_DATA_W     = 18;
    localparam int DEF_ADDR_BITS  = 16;
    localparam int DEF_LOG_DEPTH  = 6;
    localparam int DEF_LEN_BITS   = 5;
    localparam int DEF_FILL_VALUE = 0;

    // End is one bit wider than start so a run ending at the top of the space never wraps.
    typedef struct packed {
        logic [DEF_ADDR_BITS-1:0] start;
        logic [DEF_ADDR_BITS:0]   run_end;
        logic [DEF_DATA_W-1:0]    data;
    } run_t;

    function automatic int run_width(input int addr_bits, input int data_w);
        return addr_bits + (addr_bits + 1) + data_w;
    endfunction

endpackage

// File: rtl/varray_run_fifo.sv
// rtl/varray_run_fifo.sv - circular run queue with head/tail/count and registered flags
module varray_run_fifo
    import varray_pkg::*;
#(
    parameter int WIDTH     = run_width(DEF_ADDR_BITS, DEF_DATA_W),
    parameter int LOG_DEPTH = DEF_LOG_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WIDTH-1:0]     wdata,
    output logic [WIDTH-1:0]     rdata,
    output logic [LOG_DEPTH:0]   count,
    output logic                 full,
    output logic                 empty
);

    localparam int DEPTH = 1 << LOG_DEPTH;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [LOG_DEPTH-1:0] head;
    logic [LOG_DEPTH-1:0] tail;
    logic [LOG_DEPTH:0]   count_next;

    // Caller only pushes when not full and only pops when not empty.
    assign count_next = count + {{LOG_DEPTH{1'b0}}, push} - {{LOG_DEPTH{1'b0}}, pop};
    assign rdata      = mem[tail];

    // Storage is left unreset; count gates every use of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[head] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (push) begin
                head <= head + 1'b1;
            end
            if (pop) begin
                tail <= tail + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == (LOG_DEPTH+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/varray_rle.sv
// rtl/varray_rle.sv - sparse monotonic virtual array held as a queue of address runs
module varray_rle
    import varray_pkg::*;
#(
    parameter int                DATA_W     = DEF_DATA_W,
    parameter int                ADDR_BITS  = DEF_ADDR_BITS,
    parameter int                LOG_DEPTH  = DEF_LOG_DEPTH,
    parameter int                LEN_BITS   = DEF_LEN_BITS,
    parameter logic [DATA_W-1:0] FILL_VALUE = DATA_W'(DEF_FILL_VALUE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    output logic                 wr_ready,
    input  logic [ADDR_BITS-1:0] write_addr,
    input  logic [LEN_BITS-1:0]  write_len,
    input  logic [DATA_W-1:0]    dat_w,
    output logic                 wr_err,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] read_addr,
    output logic                 rd_valid,
    output logic [DATA_W-1:0]    dat_r,
    output logic                 rd_err,
    output logic [ADDR_BITS:0]   varray_len,
    output logic [LOG_DEPTH:0]   count,
    output logic                 full,
    output logic                 empty
);

    typedef struct packed {
        logic [ADDR_BITS-1:0] start;
        logic [ADDR_BITS:0]   run_end;
        logic [DATA_W-1:0]    data;
    } run_rec_t;

    localparam int RUN_W = $bits(run_rec_t);

    run_rec_t             wr_run;
    run_rec_t             rd_run;
    logic [RUN_W-1:0]     rd_bits;
    logic [ADDR_BITS:0]   wr_addr_x;
    logic [ADDR_BITS:0]   wr_end;
    logic [ADDR_BITS:0]   rd_addr_x;
    logic [ADDR_BITS:0]   rd_next;
    logic                 wr_live;
    logic                 wr_overlap;
    logic                 push;
    logic                 pop;
    logic                 in_run;
    logic                 past_run;
    logic                 order_err;
    logic                 rd_seen;
    logic [ADDR_BITS-1:0] last_rd_addr;

    assign wr_addr_x  = {1'b0, write_addr};
    assign wr_end     = wr_addr_x + {{(ADDR_BITS+1-LEN_BITS){1'b0}}, write_len};
    assign wr_live    = we && !full && (write_len != '0);
    assign wr_overlap = wr_addr_x < varray_len;
    assign push       = wr_live && !wr_overlap;
    assign wr_ready   = !full;

    assign wr_run.start   = write_addr;
    assign wr_run.run_end = wr_end;
    assign wr_run.data    = dat_w;

    assign rd_run    = run_rec_t'(rd_bits);
    assign rd_addr_x = {1'b0, read_addr};
    assign rd_next   = rd_addr_x + 1'b1;
    assign in_run    = (read_addr >= rd_run.start) && (rd_addr_x < rd_run.run_end);
    assign past_run  = rd_addr_x >= rd_run.run_end;
    // Pop decisions use the pre-write queue, so a same-cycle push is invisible to the read.
    assign pop       = re && !empty && (rd_next >= rd_run.run_end);
    assign order_err = rd_seen && (read_addr <= last_rd_addr);

    varray_run_fifo #(
        .WIDTH     (RUN_W),
        .LOG_DEPTH (LOG_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (wr_run),
        .rdata (rd_bits),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            varray_len   <= '0;
            rd_valid     <= 1'b0;
            dat_r        <= FILL_VALUE;
            wr_err       <= 1'b0;
            rd_err       <= 1'b0;
            rd_seen      <= 1'b0;
            last_rd_addr <= '0;
        end else begin
            wr_err   <= wr_live && wr_overlap;
            rd_valid <= re;
            rd_err   <= re && ((!empty && past_run) || order_err);
            if (push) begin
                varray_len <= wr_end;
            end
            if (re) begin
                dat_r        <= (!empty && in_run) ? rd_run.data : FILL_VALUE;
                rd_seen      <= 1'b1;
                last_rd_addr <= read_addr;
            end
        end
    end

endmodule

// File: tb/tb_varray_rle.sv
// tb/tb_varray_rle.sv - directed self-checking bench for varray_rle
module tb_varray_rle;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic        wr_ready;
    logic [15:0] write_addr = '0;
    logic [4:0]  write_len = '0;
    logic [17:0] dat_w = '0;
    logic        wr_err;
    logic        re = 1'b0;
    logic [15:0] read_addr = '0;
    logic        rd_valid;
    logic [17:0] dat_r;
    logic        rd_err;
    logic [16:0] varray_len;
    logic [6:0]  count;
    logic        full;
    logic        empty;

    int n_checks = 0;
    int n_pass   = 0;

    varray_rle dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .wr_ready   (wr_ready),
        .write_addr (write_addr),
        .write_len  (write_len),
        .dat_w      (dat_w),
        .wr_err     (wr_err),
        .re         (re),
        .read_addr  (read_addr),
        .rd_valid   (rd_valid),
        .dat_r      (dat_r),
        .rd_err     (rd_err),
        .varray_len (varray_len),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0;
        re = 1'b0;
    endtask

    task automatic wr(input int a, input int l, input int d);
        we         = 1'b1;
        write_addr = 16'(a);
        write_len  = 5'(l);
        dat_w      = 18'(d);
    endtask

    task automatic rd(input int a);
        re        = 1'b1;
        read_addr = 16'(a);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    function automatic logic [17:0] wrap_data(input int i);
        return 18'((i * 37 + 5) & 32'h3FFFF);
    endfunction

    logic [17:0] exp_basic [8];

    initial begin
        exp_basic = '{18'h0, 18'h0, 18'h0, 18'h0, 18'h155, 18'h155, 18'h155, 18'h0};

        // reset state
        do_reset();
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_len", 32'(varray_len), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_dat_r", 32'(dat_r), 32'd0);

        // basic run and gap
        wr(4, 3, 'h155);
        step();
        idle();
        check("basic_count1", 32'(count), 32'd1);
        check("basic_len", 32'(varray_len), 32'd7);
        for (int a = 0; a < 8; a++) begin
            rd(a);
            step();
            check($sformatf("basic_valid_%0d", a), 32'(rd_valid), 32'd1);
            check($sformatf("basic_dat_%0d", a), 32'(dat_r), 32'(exp_basic[a]));
            check($sformatf("basic_rderr_%0d", a), 32'(rd_err), 32'd0);
            if (a == 6) begin
                check("basic_count0", 32'(count), 32'd0);
            end
        end
        idle();
        step();
        check("basic_valid_idle", 32'(rd_valid), 32'd0);

        // full and backpressure
        do_reset();
        for (int i = 0; i < 64; i++) begin
            wr(i, 1, 'h100 + i);
            step();
        end
        idle();
        check("full_full", 32'(full), 32'd1);
        check("full_wr_ready", 32'(wr_ready), 32'd0);
        check("full_count", 32'(count), 32'd64);
        wr(64, 1, 'h40);
        step();
        idle();
        check("full_drop_count", 32'(count), 32'd64);
        check("full_drop_len", 32'(varray_len), 32'd64);
        check("full_drop_err", 32'(wr_err), 32'd0);
        rd(0);
        step();
        idle();
        check("full_pop_dat", 32'(dat_r), 32'h100);
        check("full_pop_count", 32'(count), 32'd63);
        check("full_pop_full", 32'(full), 32'd0);
        wr(64, 1, 'h77);
        step();
        idle();
        check("full_accept_count", 32'(count), 32'd64);
        check("full_accept_len", 32'(varray_len), 32'd65);

        // write errors
        do_reset();
        wr(10, 2, 1);
        step();
        check("werr_first", 32'(wr_err), 32'd0);
        wr(11, 1, 2);
        step();
        check("werr_overlap", 32'(wr_err), 32'd1);
        wr(12, 0, 3);
        step();
        idle();
        check("werr_zero_len", 32'(wr_err), 32'd0);
        check("werr_len", 32'(varray_len), 32'd12);
        check("werr_count", 32'(count), 32'd1);

        // read errors
        do_reset();
        wr(0, 4, 7);
        step();
        wr(8, 2, 9);
        step();
        idle();
        rd(1);
        step();
        check("rerr_r1_dat", 32'(dat_r), 32'd7);
        check("rerr_r1_err", 32'(rd_err), 32'd0);
        rd(1);
        step();
        check("rerr_repeat_err", 32'(rd_err), 32'd1);
        check("rerr_repeat_dat", 32'(dat_r), 32'd7);
        rd(6);
        step();
        check("rerr_past_err", 32'(rd_err), 32'd1);
        check("rerr_past_dat", 32'(dat_r), 32'd0);
        check("rerr_past_count", 32'(count), 32'd1);
        rd(8);
        step();
        idle();
        check("rerr_r8_dat", 32'(dat_r), 32'd9);
        check("rerr_r8_err", 32'(rd_err), 32'd0);

        // simultaneous write and read
        do_reset();
        wr(0, 1, 3);
        rd(0);
        step();
        check("sim_empty_valid", 32'(rd_valid), 32'd1);
        check("sim_empty_dat", 32'(dat_r), 32'd0);
        check("sim_empty_count", 32'(count), 32'd1);
        wr(1, 1, 4);
        rd(0);
        step();
        idle();
        check("sim_pushpop_dat", 32'(dat_r), 32'd3);
        check("sim_pushpop_count", 32'(count), 32'd1);

        // asynchronous reset mid-operation
        do_reset();
        for (int i = 0; i < 6; i++) begin
            wr(i, 1, i + 1);
            step();
        end
        idle();
        rd(0);
        step();
        idle();
        check("mid_pre_count", 32'(count), 32'd5);
        check("mid_pre_valid", 32'(rd_valid), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check("mid_empty", 32'(empty), 32'd1);
        check("mid_valid", 32'(rd_valid), 32'd0);
        check("mid_len", 32'(varray_len), 32'd0);
        check("mid_count", 32'(count), 32'd0);
        #10;
        reset = 1'b0;
        step();

        // wrap-around: read lags write by five runs for 200 cycles
        for (int i = 0; i < 205; i++) begin
            wr(i, 1, 32'(wrap_data(i)));
            re        = (i >= 5);
            read_addr = 16'(i - 5);
            step();
            if (i >= 5) begin
                check($sformatf("wrap_dat_%0d", i - 5), 32'(dat_r), 32'(wrap_data(i - 5)));
                check($sformatf("wrap_err_%0d", i - 5), 32'(rd_err), 32'd0);
            end
        end
        idle();
        step();
        check("wrap_count", 32'(count), 32'd5);
        check("wrap_len", 32'(varray_len), 32'd205);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
